// File: rtl/sti_dac_gen_if.sv
// Bundle of all frame-request, serial and pixel-memory signals of sti_dac_gen.
// master: frame source / pixel-memory side (testbench or parent block).
// slave : sti_dac_gen itself.
// Signals: load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end (requests),
//          pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout,
//          pixel_finish, state_dbg (debug view of the FSM state), and
//          pixel_ovf only when STI_DAC_GEN_OVF_EN is defined.
// Handshake: a frame is accepted on a rising clock edge where load=1 and
// pi_ready=1; load is ignored whenever pi_ready=0. so_data is meaningful
// only while so_valid=1; pixel_addr/pixel_dataout only while pixel_wr=1.
interface sti_dac_gen_if #(
  parameter int DATA_W = 16,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
);
  logic              load;
  logic [DATA_W-1:0] pi_data;
  logic [1:0]        pi_length;
  logic              pi_fill;
  logic              pi_msb;
  logic              pi_low;
  logic              pi_end;
  logic              pi_ready;
  logic              so_data;
  logic              so_valid;
  logic              pixel_wr;
  logic [ADDR_W-1:0] pixel_addr;
  logic [PIX_W-1:0]  pixel_dataout;
  logic              pixel_finish;
  logic [1:0]        state_dbg;
`ifdef STI_DAC_GEN_OVF_EN
  logic              pixel_ovf;
`endif

  modport master (
    output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
`ifdef STI_DAC_GEN_OVF_EN
    input  pixel_ovf,
`endif
    input  pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout,
           pixel_finish, state_dbg
  );

  modport slave (
    input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
`ifdef STI_DAC_GEN_OVF_EN
    output pixel_ovf,
`endif
    output pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout,
           pixel_finish, state_dbg
  );
endinterface

// File: rtl/sti_dac_gen.sv
// sti_dac_gen: serial transmit interface plus pixel-memory writer.
// Accepts one parallel word per frame, expands it to DATA_W/2, DATA_W,
// 3*DATA_W/2 or 2*DATA_W bits, shifts it out one bit per cycle and packs
// every PIX_W serial bits (first bit in the pixel MSB) into a pixel write.
// A frame flagged pi_end is followed by zero-filling the rest of the pixel
// memory, after which pixel_finish stays high until reset.
// Ports: clk, reset (synchronous, active high), bus (sti_dac_gen_if.slave).
// Optional feature macro: STI_DAC_GEN_OVF_EN -- when defined, writes beyond
// DEPTH are suppressed and flagged on the sticky bus.pixel_ovf output; when
// undefined, the address wraps and later writes overwrite earlier pixels.
module sti_dac_gen #(
  parameter int DATA_W = 16,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  sti_dac_gen_if.slave bus
);
  localparam int FW  = 2 * DATA_W;          // widest frame
  localparam int IW  = $clog2(FW);          // frame bit index width
  localparam int CW  = IW + 1;              // frame length / bit counter width
  localparam int PCW = $clog2(PIX_W + 1);   // bits-in-pixel counter width
  localparam logic [ADDR_W:0]   WLAST = (ADDR_W + 1)'((2 ** ADDR_W) - 1);
  localparam logic [ADDR_W-1:0] ALAST = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, ZFILL, DONE} state_t;

  state_t             state_q, state_d;
  logic [FW-1:0]      frame_q, frame_in;
  logic [CW-1:0]      len_q, len_in, bit_cnt_q;
  logic               msb_q, end_q;
  logic [PIX_W-2:0]   pix_acc_q;
  logic [PCW-1:0]     pix_cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W:0]    wcnt_q;

  logic [IW-1:0]      idx;
  logic               bit_now, last_bit, grp_end, full, full_after;
  logic               wr_req, wr_en;
  logic [PIX_W-1:0]   acc_next;

  // Frame expansion: the frame is kept right-aligned and its length in len.
  always_comb begin
    frame_in = '0;
    len_in   = '0;
    case (bus.pi_length)
      2'd0: begin
        frame_in[DATA_W/2-1:0] = bus.pi_low ? bus.pi_data[DATA_W-1:DATA_W/2]
                                            : bus.pi_data[DATA_W/2-1:0];
        len_in = CW'(DATA_W / 2);
      end
      2'd1: begin
        frame_in[DATA_W-1:0] = bus.pi_data;
        len_in = CW'(DATA_W);
      end
      2'd2: begin
        frame_in[3*DATA_W/2-1:0] = bus.pi_fill
          ? {bus.pi_data, {(DATA_W/2){1'b0}}}
          : {{(DATA_W/2){1'b0}}, bus.pi_data};
        len_in = CW'(3 * DATA_W / 2);
      end
      default: begin
        frame_in = bus.pi_fill ? {bus.pi_data, {DATA_W{1'b0}}}
                               : {{DATA_W{1'b0}}, bus.pi_data};
        len_in = CW'(FW);
      end
    endcase
  end

  assign idx      = msb_q ? IW'(len_q - CW'(1) - bit_cnt_q) : IW'(bit_cnt_q);
  assign bit_now  = frame_q[idx];
  assign last_bit = (bit_cnt_q == len_q - CW'(1));
  assign grp_end  = (pix_cnt_q == PCW'(PIX_W - 1));
  assign acc_next = {pix_acc_q, bit_now};
  assign full     = wcnt_q[ADDR_W];

  assign wr_req = ((state_q == SHIFT) && grp_end) || (state_q == ZFILL);
`ifdef STI_DAC_GEN_OVF_EN
  assign wr_en  = wr_req && !full;
`else
  assign wr_en  = wr_req;
`endif
  // Memory is full once the write landing this cycle is the DEPTH-th one.
  assign full_after = full || (wr_en && (wcnt_q == WLAST));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.load) state_d = SHIFT;
      SHIFT: begin
        if (last_bit) begin
          if (!end_q)          state_d = IDLE;
          else if (full_after) state_d = DONE;
          else                 state_d = ZFILL;
        end
      end
      ZFILL: if (addr_q == ALAST) state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      msb_q     <= 1'b0;
      end_q     <= 1'b0;
      pix_acc_q <= '0;
      pix_cnt_q <= '0;
      addr_q    <= '0;
      wcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && bus.load) begin
        frame_q   <= frame_in;
        len_q     <= len_in;
        msb_q     <= bus.pi_msb;
        end_q     <= bus.pi_end;
        bit_cnt_q <= '0;
        pix_cnt_q <= '0;
      end
      if (state_q == SHIFT) begin
        bit_cnt_q <= bit_cnt_q + CW'(1);
        pix_acc_q <= acc_next[PIX_W-2:0];
        pix_cnt_q <= grp_end ? '0 : pix_cnt_q + PCW'(1);
      end
      if (wr_en) begin
        addr_q <= addr_q + ADDR_W'(1);
        // Saturate at DEPTH: only the full condition matters beyond it.
        if (!full) wcnt_q <= wcnt_q + (ADDR_W + 1)'(1);
      end
    end
  end

`ifdef STI_DAC_GEN_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (reset)                ovf_q <= 1'b0;
    else if (wr_req && full)  ovf_q <= 1'b1;
  end
  assign bus.pixel_ovf = ovf_q;
`endif

  assign bus.pi_ready      = (state_q == IDLE);
  assign bus.so_valid      = (state_q == SHIFT);
  assign bus.so_data       = (state_q == SHIFT) && bit_now;
  assign bus.pixel_wr      = wr_en;
  assign bus.pixel_addr    = addr_q;
  assign bus.pixel_dataout = ((state_q == SHIFT) && wr_en) ? acc_next : '0;
  assign bus.pixel_finish  = (state_q == DONE);
  assign bus.state_dbg     = state_q;
endmodule
